// File: rtl/stack_ctrl.sv
// stack_ctrl
//   Sequences the CPU operand stack's single-port synchronous RAM. It accepts
//   push/pop/tos strobes from the multicycle controller and owns the stack
//   pointer. It drives the RAM address and strobes, and returns read data with
//   a registered one-cycle valid pulse.
//
// Parameters
//   DW  data word width
//   AW  RAM address width (depth = 2**AW)
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   push, pop, tos  commands (exactly one at a time while idle)
//   din             push data
//   dout            registered read result
//   dout_valid      one-cycle pulse when dout has been updated
//   busy            read in flight; commands are ignored
//   full, empty     stack occupancy flags (combinational from sp)
//   err             illegal command flag
//   ram_addr, ram_we, ram_re, ram_wdata, ram_rdata   stack RAM interface
//
// Configuration
//   STACK_ERR_STICKY_EN  when defined, err stays high after the first illegal
//                        command until rst; otherwise err pulses for one cycle.
module stack_ctrl #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          tos,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_re,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {IDLE, READ} state_t;

  state_t      state;
  logic [AW:0] sp;
  logic [AW:0] spDec;
  logic        idle;
  logic        multi;
  logic        pushOk;
  logic        readOk;
  logic        illegal;

  // sp counts items, so the top entry lives at sp-1 and the next free slot at sp
  assign spDec = sp - (AW+1)'(1);
  assign full  = (sp == (AW+1)'(DEPTH));
  assign empty = (sp == '0);
  assign idle  = (state == IDLE);
  assign busy  = (state == READ);

  // Command decode happens in the command cycle itself; more than one strobe
  // is illegal, as is pushing into a full stack or reading an empty one.
  assign multi   = (push & pop) | (push & tos) | (pop & tos);
  assign pushOk  = idle & push & ~multi & ~full;
  assign readOk  = idle & (pop | tos) & ~multi & ~empty;
  assign illegal = idle & (multi | (push & full) | ((pop | tos) & empty));

  assign ram_we    = pushOk;
  assign ram_re    = readOk;
  assign ram_wdata = din;

  // Address is parked at zero whenever no RAM access is being made
  always_comb begin
    ram_addr = '0;
    if (pushOk)
      ram_addr = sp[AW-1:0];
    else if (readOk)
      ram_addr = spDec[AW-1:0];
  end

  // Stack pointer, read sequencing and the registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sp         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
`ifdef STACK_ERR_STICKY_EN
      err <= err | illegal;
`else
      err <= illegal;
`endif
      case (state)
        IDLE: begin
          if (pushOk)
            sp <= sp + (AW+1)'(1);
          if (readOk) begin
            // tos peeks; only pop consumes the entry
            if (pop)
              sp <= spDec;
            state <= READ;
          end
        end
        READ: begin
          // RAM data arrives one cycle after ram_re; capture it and pulse valid
          dout       <= ram_rdata;
          dout_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl
//   Drives stack_ctrl with directed scenarios and randomized command streams,
//   with a simple synchronous RAM attached. Every observed output is compared
//   against a queue-based stack model built from the command rules.
//   Honours STACK_ERR_STICKY_EN the same way the design does.
module tb_stack_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop, tos;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid, busy, full, empty, err;
  logic [AW-1:0] ram_addr;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] stack[$];
  logic          mBusy;
  logic          mValid;
  logic [DW-1:0] mDout;
  logic [DW-1:0] mPend;
  logic          mErr;
  logic          sticky;

  stack_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .tos        (tos),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .err        (err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read data one cycle after ram_re
  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    if (ram_re)
      ram_rdata <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    stack.delete();
    mBusy  = 1'b0;
    mValid = 1'b0;
    mDout  = '0;
    mPend  = '0;
    mErr   = 1'b0;
  endtask

  // One command cycle: drive at negedge, check the combinational RAM side,
  // then check the registered outputs just after the clock edge.
  task automatic applyStimulus(input logic p, input logic o, input logic t, input logic [DW-1:0] d);
    logic          expWe, expRe, ill;
    logic [AW-1:0] expAddr;
    int            n;
    @(negedge clk);
    push = p; pop = o; tos = t; din = d;
    #1;
    expWe = 1'b0; expRe = 1'b0; ill = 1'b0; expAddr = '0;
    n = int'(p) + int'(o) + int'(t);
    if (!mBusy) begin
      if (n > 1)
        ill = 1'b1;
      else if (p) begin
        if (stack.size() == DEPTH) ill = 1'b1;
        else begin expWe = 1'b1; expAddr = AW'(stack.size()); end
      end else if (o || t) begin
        if (stack.size() == 0) ill = 1'b1;
        else begin expRe = 1'b1; expAddr = AW'(stack.size() - 1); end
      end
    end
    checkOutput("ram_we", 32'(ram_we), 32'(expWe));
    checkOutput("ram_re", 32'(ram_re), 32'(expRe));
    checkOutput("ram_addr", 32'(ram_addr), 32'(expAddr));
    if (expWe)
      checkOutput("ram_wdata", 32'(ram_wdata), 32'(d));
    checkOutput("busy_c0", 32'(busy), 32'(mBusy));
    checkOutput("full", 32'(full), 32'(stack.size() == DEPTH));
    checkOutput("empty", 32'(empty), 32'(stack.size() == 0));
    @(posedge clk);
    #1;
    mValid = 1'b0;
    if (mBusy) begin
      mBusy  = 1'b0;
      mValid = 1'b1;
      mDout  = mPend;
    end else if (expWe) begin
      stack.push_back(d);
    end else if (expRe) begin
      mPend = stack[$];
      if (o) void'(stack.pop_back());
      mBusy = 1'b1;
    end
    mErr = ill | (sticky & mErr);
    checkOutput("err", 32'(err), 32'(mErr));
    checkOutput("dout_valid", 32'(dout_valid), 32'(mValid));
    checkOutput("dout", 32'(dout), 32'(mDout));
    checkOutput("busy", 32'(busy), 32'(mBusy));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Assert rst between clock edges and check the reset values immediately
  task automatic doReset();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0; din = '0;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_empty", 32'(empty), 32'(1));
    checkOutput("rst_full", 32'(full), 32'(0));
    checkOutput("rst_dout", 32'(dout), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    checkOutput("rst_ram_we", 32'(ram_we), 32'(0));
    checkOutput("rst_ram_re", 32'(ram_re), 32'(0));
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int            r;
    logic [DW-1:0] d;
`ifdef STACK_ERR_STICKY_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_rdata = '0;
    push = 1'b0; pop = 1'b0; tos = 1'b0; din = '0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    doReset();
    idleCycles(2);

    // push 0x11, push 0x22, tos: peek returns 0x22 and the stack keeps two items
    applyStimulus(1, 0, 0, 8'h11);
    applyStimulus(1, 0, 0, 8'h22);
    applyStimulus(0, 0, 1, '0);
    idleCycles(2);

    // two back-to-back pops, the second issued in the dout_valid cycle, then a pop on empty
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 1, 0, '0);
    idleCycles(12);
    doReset();

    // fill to full, overflow push, then pop the last value
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 0, 0, DW'(8'hA0 + i));
    applyStimulus(1, 0, 0, 8'hEE);
    applyStimulus(0, 1, 0, '0);
    idleCycles(2);

    // multiple strobes at once, and a pop while a read is in flight
    applyStimulus(1, 1, 0, 8'h55);
    applyStimulus(0, 1, 1, '0);
    applyStimulus(1, 1, 1, 8'h66);
    doReset();
    applyStimulus(1, 0, 0, 8'h33);
    applyStimulus(0, 0, 1, '0);
    applyStimulus(0, 1, 0, '0);
    idleCycles(2);

    // rst during READ aborts the read
    applyStimulus(0, 1, 0, '0);
    doReset();
    idleCycles(2);

    // randomized phases: push-heavy, pop-heavy, mixed
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      d = DW'($urandom);
      case ((i / 250) % 3)
        0: begin
          if (r < 65)      applyStimulus(1, 0, 0, d);
          else if (r < 75) applyStimulus(0, 1, 0, d);
          else if (r < 85) applyStimulus(0, 0, 1, d);
          else if (r < 90) applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), d);
          else             applyStimulus(0, 0, 0, d);
        end
        1: begin
          if (r < 15)      applyStimulus(1, 0, 0, d);
          else if (r < 70) applyStimulus(0, 1, 0, d);
          else if (r < 80) applyStimulus(0, 0, 1, d);
          else if (r < 85) applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), d);
          else             applyStimulus(0, 0, 0, d);
        end
        default: begin
          applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), d);
        end
      endcase
      if (i % 500 == 499) doReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
